// File: rtl/datapath_pipe_if.sv
// Instruction/result bus between a control unit (master) and the pipelined datapath (slave).
interface datapath_pipe_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 5
);
    logic                  valid;
    logic                  ready;
    logic [4:0]            FS;
    logic [ADDR_WIDTH-1:0] AA;
    logic [ADDR_WIDTH-1:0] BA;
    logic [ADDR_WIDTH-1:0] DA;
    logic [DATA_WIDTH-1:0] K;
    logic                  Bselect;
    logic                  cin;
    logic                  write;
    logic                  flag_en;
    logic [DATA_WIDTH-1:0] result;
    logic                  wb_valid;
    logic [3:0]            status;

    modport master (
        output valid, FS, AA, BA, DA, K, Bselect, cin, write, flag_en,
        input  ready, result, wb_valid, status
    );

    modport slave (
        input  valid, FS, AA, BA, DA, K, Bselect, cin, write, flag_en,
        output ready, result, wb_valid, status
    );
endinterface

// File: rtl/datapath_pipe.sv
// Two-stage register-file/ALU datapath with writeback forwarding, latched V/C/N/Z status
// and an iterative shift-add multiplier that stalls the instruction handshake.
module datapath_pipe #(
    parameter int DATA_WIDTH = 16,
    parameter int REG_COUNT  = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clock,
    input  logic                  reset,
    datapath_pipe_if.slave        bus,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);
    localparam int MSB       = DATA_WIDTH - 1;
    localparam int SHW       = $clog2(DATA_WIDTH);
    localparam int CW        = $clog2(DATA_WIDTH) + 1;
    localparam int REG_DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] REG_LIMIT = (ADDR_WIDTH + 1)'(REG_COUNT);

    localparam logic [4:0] FS_PASS = 5'b00000;
    localparam logic [4:0] FS_ADD  = 5'b00001;
    localparam logic [4:0] FS_SUB  = 5'b00010;
    localparam logic [4:0] FS_AND  = 5'b00011;
    localparam logic [4:0] FS_OR   = 5'b00100;
    localparam logic [4:0] FS_XOR  = 5'b00101;
    localparam logic [4:0] FS_NOT  = 5'b00110;
    localparam logic [4:0] FS_SHL  = 5'b00111;
    localparam logic [4:0] FS_SHR  = 5'b01000;
    localparam logic [4:0] FS_MUL  = 5'b01001;

    typedef enum logic {IDLE, MUL} state_t;
    state_t state, state_next;

    // Entries at or above REG_COUNT are never written, so they stay zero and fold away.
    logic [DATA_WIDTH-1:0] regs [REG_DEPTH];

    logic [DATA_WIDTH-1:0] wb_result;
    logic                  wb_valid, wb_write, wb_flag_en;
    logic [ADDR_WIDTH-1:0] wb_da;
    logic [3:0]            wb_flags;
    logic [3:0]            status;

    logic [DATA_WIDTH-1:0] mul_a, mul_b, mul_acc, mul_acc_next;
    logic [CW-1:0]         mul_count;
    logic [ADDR_WIDTH-1:0] mul_da;
    logic                  mul_write, mul_flag_en, mul_last;

    logic [DATA_WIDTH-1:0] a_op, b_reg, b_op, alu_y;
    logic [DATA_WIDTH:0]   sum;
    logic                  alu_c, alu_v, is_mul;

    function automatic logic in_range(input logic [ADDR_WIDTH-1:0] addr);
        return {1'b0, addr} < REG_LIMIT;
    endfunction

    // An operand whose register is being written back this cycle takes the writeback value.
    always_comb begin
        a_op  = '0;
        b_reg = '0;
        if (in_range(bus.AA)) a_op  = regs[bus.AA];
        if (in_range(bus.BA)) b_reg = regs[bus.BA];
        if (wb_valid && wb_write && in_range(wb_da)) begin
            if (wb_da == bus.AA) a_op  = wb_result;
            if (wb_da == bus.BA) b_reg = wb_result;
        end
        b_op   = bus.Bselect ? bus.K : b_reg;
        is_mul = (bus.FS == FS_MUL);
    end

    always_comb begin
        sum   = '0;
        alu_y = '0;
        alu_c = 1'b0;
        alu_v = 1'b0;
        case (bus.FS)
            FS_PASS: alu_y = a_op;
            FS_ADD: begin
                sum   = {1'b0, a_op} + {1'b0, b_op} + {{DATA_WIDTH{1'b0}}, bus.cin};
                alu_y = sum[MSB:0];
                alu_c = sum[DATA_WIDTH];
                alu_v = (a_op[MSB] == b_op[MSB]) && (alu_y[MSB] != a_op[MSB]);
            end
            FS_SUB: begin
                sum   = {1'b0, a_op} + {1'b0, ~b_op} + (DATA_WIDTH + 1)'(1);
                alu_y = sum[MSB:0];
                alu_c = sum[DATA_WIDTH];
                alu_v = (a_op[MSB] != b_op[MSB]) && (alu_y[MSB] != a_op[MSB]);
            end
            FS_AND:  alu_y = a_op & b_op;
            FS_OR:   alu_y = a_op | b_op;
            FS_XOR:  alu_y = a_op ^ b_op;
            FS_NOT:  alu_y = ~a_op;
            FS_SHL:  alu_y = a_op << b_op[SHW-1:0];
            FS_SHR:  alu_y = a_op >> b_op[SHW-1:0];
            default: alu_y = '0;
        endcase
    end

    assign mul_acc_next = mul_b[0] ? mul_acc + mul_a : mul_acc;
    assign mul_last     = (mul_count == CW'(DATA_WIDTH - 1));

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        bus.ready  = 1'b0;
        case (state)
            IDLE: begin
                bus.ready = 1'b1;
                if (bus.valid && is_mul) state_next = MUL;
            end
            MUL: if (mul_last) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < REG_DEPTH; i++) regs[i] <= '0;
            wb_result   <= '0;
            wb_valid    <= 1'b0;
            wb_write    <= 1'b0;
            wb_flag_en  <= 1'b0;
            wb_da       <= '0;
            wb_flags    <= '0;
            status      <= '0;
            mul_a       <= '0;
            mul_b       <= '0;
            mul_acc     <= '0;
            mul_count   <= '0;
            mul_da      <= '0;
            mul_write   <= 1'b0;
            mul_flag_en <= 1'b0;
        end else begin
            wb_valid <= 1'b0;
            if (wb_valid) begin
                if (wb_write && in_range(wb_da)) regs[wb_da] <= wb_result;
                if (wb_flag_en) status <= wb_flags;
            end
            case (state)
                IDLE: if (bus.valid) begin
                    if (is_mul) begin
                        mul_a       <= a_op;
                        mul_b       <= b_op;
                        mul_acc     <= '0;
                        mul_count   <= '0;
                        mul_da      <= bus.DA;
                        mul_write   <= bus.write;
                        mul_flag_en <= bus.flag_en;
                    end else begin
                        wb_valid   <= 1'b1;
                        wb_result  <= alu_y;
                        wb_da      <= bus.DA;
                        wb_write   <= bus.write;
                        wb_flag_en <= bus.flag_en;
                        wb_flags   <= {alu_v, alu_c, alu_y[MSB], alu_y == '0};
                    end
                end
                MUL: begin
                    mul_acc   <= mul_acc_next;
                    mul_a     <= mul_a << 1;
                    mul_b     <= mul_b >> 1;
                    mul_count <= mul_count + CW'(1);
                    if (mul_last) begin
                        wb_valid   <= 1'b1;
                        wb_result  <= mul_acc_next;
                        wb_da      <= mul_da;
                        wb_write   <= mul_write;
                        wb_flag_en <= mul_flag_en;
                        wb_flags   <= {2'b00, mul_acc_next[MSB], mul_acc_next == '0};
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.result   = wb_result;
    assign bus.wb_valid = wb_valid;
    assign bus.status   = status;
    assign rd_data      = in_range(rd_addr) ? regs[rd_addr] : '0;
endmodule

// File: tb/tb_datapath_pipe.sv
// Directed bench for datapath_pipe: a 16-bit/32-register instance and an 8-bit/8-register instance.
module tb_datapath_pipe;
    localparam logic [4:0] OP_PASS = 5'b00000;
    localparam logic [4:0] OP_ADD  = 5'b00001;
    localparam logic [4:0] OP_SUB  = 5'b00010;
    localparam logic [4:0] OP_AND  = 5'b00011;
    localparam logic [4:0] OP_OR   = 5'b00100;
    localparam logic [4:0] OP_XOR  = 5'b00101;
    localparam logic [4:0] OP_NOT  = 5'b00110;
    localparam logic [4:0] OP_SHL  = 5'b00111;
    localparam logic [4:0] OP_SHR  = 5'b01000;
    localparam logic [4:0] OP_MUL  = 5'b01001;
    localparam logic [4:0] OP_BAD  = 5'b01010;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    datapath_pipe_if #(.DATA_WIDTH(16), .ADDR_WIDTH(5)) bus16 ();
    datapath_pipe_if #(.DATA_WIDTH(8),  .ADDR_WIDTH(4)) bus8 ();

    logic [4:0]  rd_addr16;
    logic [15:0] rd_data16;
    logic [3:0]  rd_addr8;
    logic [7:0]  rd_data8;

    datapath_pipe #(.DATA_WIDTH(16), .REG_COUNT(32), .ADDR_WIDTH(5)) dut16 (
        .clock(clock), .reset(reset), .bus(bus16), .rd_addr(rd_addr16), .rd_data(rd_data16)
    );

    datapath_pipe #(.DATA_WIDTH(8), .REG_COUNT(8), .ADDR_WIDTH(4)) dut8 (
        .clock(clock), .reset(reset), .bus(bus8), .rd_addr(rd_addr8), .rd_data(rd_data8)
    );

    int total = 0;
    int bad   = 0;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic idleCycle();
        @(posedge clock);
        #1;
    endtask

    // Presents one instruction for a single cycle; returns one step into the following cycle.
    task automatic applyStimulus(input logic [4:0] fs, input logic [4:0] aa, input logic [4:0] ba,
                                 input logic [4:0] da, input logic [15:0] k, input logic bsel,
                                 input logic cin, input logic wr, input logic fen);
        bus16.FS = fs;  bus16.AA = aa;  bus16.BA = ba;  bus16.DA = da;  bus16.K = k;
        bus16.Bselect = bsel;  bus16.cin = cin;  bus16.write = wr;  bus16.flag_en = fen;
        bus16.valid = 1'b1;
        @(posedge clock);
        #1;
        bus16.valid = 1'b0;
    endtask

    task automatic applyStimulus8(input logic [4:0] fs, input logic [3:0] aa, input logic [3:0] da,
                                  input logic [7:0] k, input logic cin, input logic wr, input logic fen);
        bus8.FS = fs;  bus8.AA = aa;  bus8.BA = '0;  bus8.DA = da;  bus8.K = k;
        bus8.Bselect = 1'b1;  bus8.cin = cin;  bus8.write = wr;  bus8.flag_en = fen;
        bus8.valid = 1'b1;
        @(posedge clock);
        #1;
        bus8.valid = 1'b0;
    endtask

    task automatic aluCase(input string tag, input logic [4:0] fs, input logic [4:0] aa,
                           input logic [15:0] k, input logic [15:0] expected);
        applyStimulus(fs, aa, 5'd0, 5'd31, k, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput({tag, "_valid"}, bus16.wb_valid, 1);
        checkOutput(tag, bus16.result, expected);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int low;
        int seen;
        bus16.valid = 1'b0;  bus16.FS = '0;  bus16.AA = '0;  bus16.BA = '0;  bus16.DA = '0;
        bus16.K = '0;  bus16.Bselect = 1'b0;  bus16.cin = 1'b0;  bus16.write = 1'b0;  bus16.flag_en = 1'b0;
        bus8.valid = 1'b0;  bus8.FS = '0;  bus8.AA = '0;  bus8.BA = '0;  bus8.DA = '0;
        bus8.K = '0;  bus8.Bselect = 1'b0;  bus8.cin = 1'b0;  bus8.write = 1'b0;  bus8.flag_en = 1'b0;
        rd_addr16 = 5'd0;
        rd_addr8  = 4'd0;

        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        checkOutput("rst_ready",    bus16.ready, 1);
        checkOutput("rst_wb_valid", bus16.wb_valid, 0);
        checkOutput("rst_result",   bus16.result, 0);
        checkOutput("rst_status",   bus16.status, 0);
        checkOutput("rst_ready8",   bus8.ready, 1);

        // Register loads and a dependent add
        applyStimulus(OP_ADD, 5'd0, 5'd0, 5'd1, 16'd5, 1'b1, 1'b0, 1'b1, 1'b0);
        checkOutput("load_r1_valid", bus16.wb_valid, 1);
        checkOutput("load_r1",       bus16.result, 16'd5);
        applyStimulus(OP_ADD, 5'd1, 5'd0, 5'd2, 16'd3, 1'b1, 1'b0, 1'b1, 1'b0);
        checkOutput("r2_valid", bus16.wb_valid, 1);
        checkOutput("r2",       bus16.result, 16'd8);
        rd_addr16 = 5'd2;
        idleCycle();
        checkOutput("idle_wb_valid", bus16.wb_valid, 0);
        checkOutput("rd_r2",         rd_data16, 16'd8);
        rd_addr16 = 5'd1;
        #1;
        checkOutput("rd_r1", rd_data16, 16'd5);

        // Back-to-back dependency chain on both A and B operands
        applyStimulus(OP_ADD, 5'd1, 5'd0, 5'd3, 16'd1, 1'b1, 1'b0, 1'b1, 1'b0);
        checkOutput("fwd_ready", bus16.ready, 1);
        applyStimulus(OP_ADD, 5'd3, 5'd0, 5'd4, 16'd1, 1'b1, 1'b0, 1'b1, 1'b0);
        checkOutput("fwd_r4", bus16.result, 16'd7);
        applyStimulus(OP_ADD, 5'd0, 5'd4, 5'd5, 16'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("fwd_b_r5", bus16.result, 16'd7);
        rd_addr16 = 5'd4;
        idleCycle();
        checkOutput("rd_r4", rd_data16, 16'd7);

        // Flags: 0x8000 - 0x8000 then 0x7FFF + 1
        applyStimulus(OP_ADD, 5'd0, 5'd0, 5'd6, 16'h8000, 1'b1, 1'b0, 1'b1, 1'b0);
        applyStimulus(OP_SUB, 5'd6, 5'd6, 5'd7, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("sub_result", bus16.result, 16'h0000);
        idleCycle();
        checkOutput("sub_status", bus16.status, 4'b0101);
        applyStimulus(OP_ADD, 5'd0, 5'd0, 5'd7, 16'h7FFF, 1'b1, 1'b0, 1'b1, 1'b0);
        idleCycle();
        checkOutput("status_hold", bus16.status, 4'b0101);
        applyStimulus(OP_ADD, 5'd7, 5'd0, 5'd12, 16'h0001, 1'b1, 1'b0, 1'b0, 1'b1);
        checkOutput("ovf_result", bus16.result, 16'h8000);
        rd_addr16 = 5'd12;
        idleCycle();
        checkOutput("ovf_status",  bus16.status, 4'b1010);
        checkOutput("nowrite_r12", rd_data16, 16'h0000);

        aluCase("and",  OP_AND,  5'd1, 16'h000C, 16'h0004);
        aluCase("or",   OP_OR,   5'd1, 16'h000A, 16'h000F);
        aluCase("xor",  OP_XOR,  5'd1, 16'h00FF, 16'h00FA);
        aluCase("not",  OP_NOT,  5'd1, 16'h0000, 16'hFFFA);
        aluCase("shl",  OP_SHL,  5'd1, 16'h0013, 16'h0028);
        aluCase("shr",  OP_SHR,  5'd6, 16'h001F, 16'h0001);
        aluCase("pass", OP_PASS, 5'd1, 16'h1234, 16'h0005);
        aluCase("bad",  OP_BAD,  5'd1, 16'h1234, 16'h0000);

        // Multiply 0x12 * 0x34
        applyStimulus(OP_ADD, 5'd0, 5'd0, 5'd8, 16'h0012, 1'b1, 1'b0, 1'b1, 1'b0);
        applyStimulus(OP_ADD, 5'd0, 5'd0, 5'd9, 16'h0034, 1'b1, 1'b0, 1'b1, 1'b0);
        applyStimulus(OP_MUL, 5'd8, 5'd9, 5'd10, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0);
        low = 0;
        while (bus16.ready == 1'b0 && low < 40) begin
            low++;
            idleCycle();
        end
        checkOutput("mul_ready_low", low, 16);
        checkOutput("mul_wb_valid",  bus16.wb_valid, 1);
        checkOutput("mul_result",    bus16.result, 16'h03A8);
        rd_addr16 = 5'd10;
        idleCycle();
        checkOutput("rd_r10", rd_data16, 16'h03A8);

        // Reset during the seventh multiply iteration
        applyStimulus(OP_MUL, 5'd8, 5'd9, 5'd11, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0);
        repeat (6) idleCycle();
        reset = 1'b1;
        idleCycle();
        reset = 1'b0;
        checkOutput("abort_ready",    bus16.ready, 1);
        checkOutput("abort_wb_valid", bus16.wb_valid, 0);
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            if (bus16.wb_valid) seen++;
            idleCycle();
        end
        checkOutput("abort_no_wb", seen, 0);
        checkOutput("abort_r10",   rd_data16, 16'h0000);
        rd_addr16 = 5'd11;
        #1;
        checkOutput("abort_r11", rd_data16, 16'h0000);

        // Narrow instance: carry with cin and an out-of-range destination
        applyStimulus8(OP_ADD, 4'd0, 4'd1, 8'hF0, 1'b0, 1'b1, 1'b0);
        applyStimulus8(OP_ADD, 4'd1, 4'd2, 8'h20, 1'b1, 1'b1, 1'b1);
        checkOutput("w8_add", bus8.result, 8'h11);
        idleCycle();
        checkOutput("w8_status", bus8.status, 4'b0100);
        applyStimulus8(OP_ADD, 4'd0, 4'd9, 8'h55, 1'b0, 1'b1, 1'b0);
        checkOutput("w8_oor_result", bus8.result, 8'h55);
        rd_addr8 = 4'd9;
        idleCycle();
        checkOutput("w8_oor_rd", rd_data8, 8'h00);
        rd_addr8 = 4'd1;
        #1;
        checkOutput("w8_rd_r1", rd_data8, 8'hF0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
